// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone-attached prescaled countdown timer with level interrupt
//
// Ports:
//   sys_clk, sys_rst            : clock (rising edge) and asynchronous active-high reset
//   wb_cyc, wb_stb, wb_we       : Wishbone cycle, strobe, write enable
//   wb_tag                      : cycle tag, ignored
//   wb_sel, wb_adr, wb_mosi     : byte selects, byte address (adr[4:2] decoded), write data
//   wb_miso, wb_ack, wb_err     : registered read data and one-cycle response
//   irq                         : registered level interrupt (EXPIRED & IRQEN)
module wb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [TAG_WIDTH-1:0]  wb_tag,
    input  logic [3:0]            wb_sel,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [31:0]           wb_mosi,
    output logic [31:0]           wb_miso,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  irq
);
    localparam logic [2:0] OFS_CTRL     = 3'd0;
    localparam logic [2:0] OFS_PRESCALE = 3'd1;
    localparam logic [2:0] OFS_RELOAD   = 3'd2;
    localparam logic [2:0] OFS_COUNT    = 3'd3;
    localparam logic [2:0] OFS_STATUS   = 3'd4;

    // ctrl bits: [0] EN, [1] AUTO, [2] IRQEN
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] miso_q, miso_d;
    logic        irq_q, irq_d;

    logic        req, bad_adr, wr_any;
    logic        wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic        tick, expire;
    logic [2:0]  idx;
    logic [31:0] cur_val, byte_mask, wr_val;

    logic unused_inputs;
    assign unused_inputs = ^{wb_tag, wb_adr};

    always_comb begin
        idx     = wb_adr[4:2];
        req     = wb_cyc & wb_stb & ~ack_q;
        bad_adr = (idx > OFS_STATUS);

        case (idx)
            OFS_CTRL:     cur_val = {29'd0, ctrl_q};
            OFS_PRESCALE: cur_val = {16'd0, prescale_q};
            OFS_RELOAD:   cur_val = reload_q;
            OFS_COUNT:    cur_val = count_q;
            OFS_STATUS:   cur_val = {31'd0, expired_q};
            default:      cur_val = 32'd0;
        endcase

        byte_mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
        wr_val    = (cur_val & ~byte_mask) | (wb_mosi & byte_mask);

        // A write with no byte lanes selected is acknowledged but touches nothing,
        // including the prescaler restart.
        wr_any      = req & wb_we & ~bad_adr & (|wb_sel);
        wr_ctrl     = wr_any & (idx == OFS_CTRL);
        wr_prescale = wr_any & (idx == OFS_PRESCALE);
        wr_reload   = wr_any & (idx == OFS_RELOAD);
        wr_count    = wr_any & (idx == OFS_COUNT);
        wr_status   = wr_any & (idx == OFS_STATUS);

        tick   = ctrl_q[0] & (pcnt_q == prescale_q);
        // A COUNT write on the tick cycle swallows that tick entirely.
        expire = tick & ~wr_count & (count_q == 32'd0);

        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        expired_d  = expired_q;

        if (tick && !wr_count) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = reload_q;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        // Bus writes are applied after the timer so an explicit write wins.
        if (wr_ctrl && wb_sel[0]) begin
            ctrl_d = wb_mosi[2:0];
        end
        if (wr_prescale) begin
            prescale_d = wr_val[15:0];
        end
        if (wr_reload) begin
            reload_d = wr_val;
        end
        if (wr_count) begin
            count_d = wr_val;
        end
        // W1C loses against a simultaneous expiry.
        if (wr_status && wb_sel[0] && wb_mosi[0] && !expire) begin
            expired_d = 1'b0;
        end

        if (wr_ctrl || wr_prescale || !ctrl_q[0] || tick) begin
            pcnt_d = 16'd0;
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end

        ack_d  = req & ~bad_adr;
        err_d  = req & bad_adr;
        miso_d = (req && !wb_we && !bad_adr) ? cur_val : 32'd0;
        irq_d  = expired_q & ctrl_q[2];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ctrl_q     <= 3'd0;
            prescale_q <= 16'd0;
            reload_q   <= 32'd0;
            count_q    <= 32'd0;
            expired_q  <= 1'b0;
            pcnt_q     <= 16'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            miso_q     <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            pcnt_q     <= pcnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            miso_q     <= miso_d;
            irq_q      <= irq_d;
        end
    end

    assign wb_ack  = ack_q;
    assign wb_err  = err_q;
    assign wb_miso = miso_q;
    assign irq     = irq_q;

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of wb_adr.
REQ-002 SHALL have parameter TAG_WIDTH, default 3, width of wb_tag (accepted, ignored).
REQ-003 SHALL have port sys_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wb_cyc  input  1  Wishbone cycle.
REQ-006 SHALL have port wb_stb  input  1  Wishbone strobe.
REQ-007 SHALL have port wb_we  input  1  write enable.
REQ-008 SHALL have port wb_tag  input  TAG_WIDTH  cycle tag, unused.
REQ-009 SHALL have port wb_sel  input  4  byte selects.
REQ-010 SHALL have port wb_adr  input  ADDR_WIDTH  byte address; only adr[4:2] decoded.
REQ-011 SHALL have port wb_mosi  input  32  write data.
REQ-012 SHALL have port wb_miso  output  32  read data.
REQ-013 SHALL have port wb_ack  output  1  cycle acknowledge.
REQ-014 SHALL have port wb_err  output  1  cycle error.
REQ-015 SHALL have port irq  output  1  level interrupt to CPU.

Function
REQ-016 Register map (offset): 0x00 CTRL {bit0 EN, bit1 AUTO, bit2 IRQEN}, 0x04 PRESCALE [15:0], 0x08 RELOAD [31:0], 0x0C COUNT [31:0], 0x10 STATUS {bit0 EXPIRED, W1C}; unused bits read 0.
REQ-017 Request = wb_cyc & wb_stb & ~wb_ack; ack or err SHALL assert exactly one cycle after request, for one cycle.
REQ-018 Offsets 0x14-0x1C SHALL return wb_err=1, wb_ack=0, no state change, wb_miso=0.
REQ-019 Writes SHALL honour wb_sel per byte; wb_sel=0 write acks with no change.
REQ-020 wb_miso SHALL be registered, valid in the ack cycle, and 0 when ack is low.
REQ-021 Prescaler pcnt SHALL count 0..PRESCALE while EN=1; at pcnt==PRESCALE it wraps to 0 and emits one-cycle tick; PRESCALE=0 means tick every cycle.
REQ-022 EN=0 SHALL hold pcnt at 0 and COUNT frozen; writing CTRL or PRESCALE SHALL reset pcnt to 0.
REQ-023 On tick with COUNT!=0: COUNT decrements by 1.
REQ-024 On tick with COUNT==0: EXPIRED set; AUTO=1 -> COUNT<=RELOAD, EN unchanged; AUTO=0 -> COUNT stays 0, EN cleared.
REQ-025 Bus write to COUNT in same cycle as tick SHALL win (written value kept, no decrement, no expiry from that tick).
REQ-026 STATUS W1C in same cycle as expiry SHALL leave EXPIRED=1 (set wins).
REQ-027 RELOAD write SHALL NOT affect COUNT until next reload.
REQ-028 irq SHALL be registered: irq = EXPIRED & IRQEN, one cycle after either changes.
REQ-029 Bus access while wb_cyc drops mid-cycle SHALL still complete its write internally; ack is not retracted.

Reset
REQ-030 sys_rst=1 SHALL asynchronously clear CTRL, PRESCALE, RELOAD, COUNT, STATUS, pcnt, wb_ack, wb_err, wb_miso, irq to 0.
REQ-031 Reset asserted mid-transaction SHALL abort it; no ack after reset release for that request.
REQ-032 First request one cycle after reset release SHALL be served normally.

Verification
REQ-033 Reset, read offsets 0x00-0x10 -> all return 0, each ack one cycle after stb.
REQ-034 PRESCALE=3, COUNT=2, CTRL=0x1 -> COUNT 2->1->0 every 4 cycles; 4 cycles later EXPIRED=1, EN=0, COUNT=0.
REQ-035 RELOAD=5, COUNT=0, PRESCALE=0, CTRL=0x7 -> expiry next cycle, COUNT=5, irq=1 one cycle after EXPIRED; W1C STATUS -> irq=0 next cycle; period 6 cycles.
REQ-036 Write COUNT=0x100 on tick cycle -> reads 0x100, no expiry; W1C STATUS on expiry cycle -> EXPIRED stays 1.
REQ-037 Write 0xAABBCCDD to RELOAD with sel=0b0101 -> reads 0x00BB00DD; access offset 0x18 -> wb_err=1, wb_ack=0.
REQ-038 Assert sys_rst during write request -> no ack, all registers 0; request after release acks normally.
